// File: rtl/bintogray_pkg.sv
// bintogray_pkg: shared Gray encode/decode helpers for bintogray.
// Helpers operate on MAX_W bits; callers zero-extend and truncate to their WIDTH.
package bintogray_pkg;
    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper Gray bits decode to zeros, so truncation stays exact.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/bintogray_gray2bin_dec.sv
// gray2bin_dec: combinational Gray-to-binary decoder chain.
module gray2bin_dec
    import bintogray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);
    assign b = WIDTH'(gray2bin(MAX_W'(g)));
endmodule

// File: rtl/bintogray.sv
// bintogray: binary-to-Gray converter with combinational and registered outputs.
// BINTOGRAY_DECODE_EN adds the B_chk decode and registered chk_err self-check.
module bintogray
    import bintogray_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] G_q,
    output logic             q_valid
`ifdef BINTOGRAY_DECODE_EN
    ,
    output logic [WIDTH-1:0] B_chk,
    output logic             chk_err
`endif
);
    assign G = WIDTH'(bin2gray(MAX_W'(B)));

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    G_q     <= '0;
                    q_valid <= 1'b0;
                end else begin
                    if (in_valid) G_q <= G;
                    q_valid <= in_valid;
                end
            end
        end else begin : g_comb
            assign G_q     = G;
            assign q_valid = in_valid;
        end
    endgenerate

`ifdef BINTOGRAY_DECODE_EN
    gray2bin_dec #(.WIDTH(WIDTH)) u_dec (.g(G), .b(B_chk));

    always_ff @(posedge clk) chk_err <= rst ? 1'b0 : (in_valid && (B_chk != B));
`endif
endmodule

// File: tb/tb_bintogray.sv
// tb_bintogray: table-driven and randomized self-checking bench for bintogray.
module tb_bintogray;
    typedef struct {
        logic [3:0] b;
        logic [3:0] g;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] b4 = '0;
    logic       iv = 1'b0;
    logic [3:0] g4, gq4;
    logic       qv4;
    logic [7:0] b8 = '0;
    logic [7:0] g8, gq8;
    logic       qv8;
`ifdef BINTOGRAY_DECODE_EN
    logic [3:0] bchk4;
    logic       cerr4;
    logic [7:0] bchk8;
    logic       cerr8;
`endif

    int total = 0;
    int bad   = 0;

    vec_t       vecs[16];
    logic [3:0] gtab[16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    bintogray #(.WIDTH(4), .REG_OUT(1)) dut (
        .clk(clk), .rst(rst), .B(b4), .in_valid(iv), .G(g4), .G_q(gq4), .q_valid(qv4)
`ifdef BINTOGRAY_DECODE_EN
        , .B_chk(bchk4), .chk_err(cerr4)
`endif
    );

    bintogray #(.WIDTH(8), .REG_OUT(0)) dut8 (
        .clk(clk), .rst(rst), .B(b8), .in_valid(iv), .G(g8), .G_q(gq8), .q_valid(qv8)
`ifdef BINTOGRAY_DECODE_EN
        , .B_chk(bchk8), .chk_err(cerr8)
`endif
    );

    always #5 clk = ~clk;

    // Reference: each Gray bit is set when a binary bit and its upper neighbour differ.
    function automatic int ref_gray(input int b, input int w);
        int g = 0;
        for (int i = 0; i < w; i++) begin
            int hi = (i == w-1) ? 0 : (b >> (i+1)) & 1;
            if (((b >> i) & 1) != hi) g += (1 << i);
        end
        return g;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_gq;
        int exp_qv;
        for (int i = 0; i < 16; i++) vecs[i] = '{b: 4'(i), g: gtab[i]};
        // Reset held for two edges
        tick();
        tick();
        chk("reset_gq", 32'(gq4), 32'h0);
        chk("reset_qv", 32'(qv4), 32'h0);
        // Exhaustive combinational sweep
        for (int i = 0; i < 16; i++) begin
            b4 = vecs[i].b;
            #5;
            chk($sformatf("sweep_g[%0d]", i), 32'(g4), 32'(vecs[i].g));
        end
        // Single-bit change between adjacent codes, including wrap
        for (int i = 0; i < 16; i++) begin
            int a = ref_gray(i, 4);
            int c = ref_gray((i + 1) % 16, 4);
            chk($sformatf("onebit_ref[%0d]", i), 32'($countones(32'(a ^ c))), 32'd1);
            chk($sformatf("onebit_dut[%0d]", i), 32'($countones(32'(gtab[i] ^ gtab[(i+1)%16]))), 32'd1);
        end
        // Registered path
        tick();
        rst = 1'b0;
        iv  = 1'b1;
        b4  = 4'd5;
        tick();
        chk("reg_gq_5", 32'(gq4), 32'b0111);
        chk("reg_qv_5", 32'(qv4), 32'h1);
        iv = 1'b0;
        b4 = 4'd9;
        tick();
        chk("hold_gq", 32'(gq4), 32'b0111);
        chk("hold_qv", 32'(qv4), 32'h0);
        // Reset has priority over a valid input on the same edge
        rst = 1'b1;
        iv  = 1'b1;
        b4  = 4'd12;
        #1;
        chk("rstpri_g", 32'(g4), 32'b1010);
        tick();
        chk("rstpri_gq", 32'(gq4), 32'h0);
        chk("rstpri_qv", 32'(qv4), 32'h0);
        chk("rstpri_g_after", 32'(g4), 32'b1010);
        rst = 1'b0;
        iv  = 1'b0;
        // Width scaling with pass-through register stage
        b8 = 8'hFF;
        #1;
        chk("w8_ff", 32'(g8), 32'h80);
        chk("w8_ff_gq", 32'(gq8), 32'h80);
        b8 = 8'hA5;
        #1;
        chk("w8_a5", 32'(g8), 32'hF7);
        tick();
        // Randomized stream against the reference model
        exp_gq = 0;
        exp_qv = 0;
        for (int n = 0; n < 1000; n++) begin
            b4 = 4'($urandom_range(0, 15));
            b8 = 8'($urandom_range(0, 255));
            iv = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_g4", 32'(g4), 32'(ref_gray(int'(b4), 4)));
            chk("rnd_g8", 32'(g8), 32'(ref_gray(int'(b8), 8)));
`ifdef BINTOGRAY_DECODE_EN
            chk("rnd_bchk4", 32'(bchk4), 32'(b4));
            chk("rnd_bchk8", 32'(bchk8), 32'(b8));
`endif
            if (iv) exp_gq = ref_gray(int'(b4), 4);
            exp_qv = int'(iv);
            tick();
            chk("rnd_gq", 32'(gq4), 32'(exp_gq));
            chk("rnd_qv", 32'(qv4), 32'(exp_qv));
`ifdef BINTOGRAY_DECODE_EN
            chk("rnd_cerr", 32'(cerr4), 32'h0);
`endif
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
